pdp8_mem_unit: RTL
==================

// Module: pdp8_mem_unit
// PURPOSE
//  Unified PDP-8 main memory, directly upstream of the IFD. Serves the IFD instruction fetch
//  port and the execution unit data read/write ports from one storage array.
//  A load FSM fills the array from the bench/loader before execution starts.
//  mem_ready tells IFD/EXEC that fetches may begin.
// PARAMETERS
//  ADDR_WIDTH  12     address width; array depth = 2**ADDR_WIDTH words
//  DATA_WIDTH  12     word width
// PORTS
//  clk             in   1           system clock; all logic on posedge
//  reset           in   1           synchronous, active-high reset
//  ld_start        in   1           pulse: enter LOAD state
//  ld_valid        in   1           load word valid this cycle (LOAD state only)
//  ld_addr         in   ADDR_WIDTH  load word address
//  ld_data         in   DATA_WIDTH  load word data
//  ld_end          in   1           pulse: loading finished, go to RUN
//  mem_ready       out  1           1 in RUN state only
//  ifu_rd_req      in   1           IFD fetch request
//  ifu_rd_addr     in   ADDR_WIDTH  IFD fetch address
//  ifu_rd_data     out  DATA_WIDTH  fetched word
//  exec_rd_req     in   1           EXEC data read request
//  exec_rd_addr    in   ADDR_WIDTH  EXEC read address
//  exec_rd_data    out  DATA_WIDTH  EXEC read word
//  exec_wr_req     in   1           EXEC write request
//  exec_wr_addr    in   ADDR_WIDTH  EXEC write address
//  exec_wr_data    in   DATA_WIDTH  EXEC write word
//  err_conflict    out  1           1-cycle pulse: illegal request combination dropped
// BEHAVIOUR
//  Reset: state=IDLE; mem_ready=0; ifu_rd_data=0; exec_rd_data=0; err_conflict=0.
//   Array contents are NOT cleared by reset.
//  FSM:
//   IDLE -> LOAD on ld_start.
//   LOAD: each cycle with ld_valid, writes mem[ld_addr]=ld_data.
//         On ld_end -> RUN. A ld_valid in the same cycle as ld_end is still written.
//   RUN: mem_ready=1. ld_start returns to LOAD (mem_ready drops next cycle).
//        ld_valid/ld_end are ignored outside LOAD.
//  Reads, RUN only:
//   Request sampled at posedge N; ifu_rd_data/exec_rd_data valid from posedge N+1.
//   Data holds until the next accepted read on that port.
//  Writes, RUN only: exec_wr_req at posedge N updates the array at posedge N.
//  Same-cycle ordering:
//   IFU read and EXEC write to the same address in one cycle: read returns the OLD word.
//   EXEC read and IFU read are independent; both are served in the same cycle.
//   exec_rd_req & exec_wr_req together: read served, write dropped, err_conflict=1 next cycle.
//  Requests outside RUN:
//   IFU/EXEC requests in IDLE or LOAD are dropped; read outputs hold their value.
//   err_conflict pulses next cycle.
//  Address wrap: none needed; full 2**ADDR_WIDTH space is addressable.
//   Unknown (X/Z) address bits -> read data X is allowed; writes with X address are dropped.
//  Reset mid-operation: state returns to IDLE next edge; a pending read is discarded
//   (outputs go to 0). Array contents written before reset are retained.
// TESTING
//  1 reset; ld_start; load 0200=7200, 0201=1300, 0300=0005; ld_end ->
//    mem_ready=1 one cycle after ld_end.
//  2 RUN; ifu_rd_req@0200 at edge N -> ifu_rd_data=7200 from edge N+1, held while req=0.
//  3 exec_wr 0300<=0017 and ifu_rd@0300 in the same cycle -> ifu_rd_data=0005;
//    next ifu_rd@0300 -> 0017.
//  4 exec_rd_req@0201 and exec_wr_req@0201=4444 together -> exec_rd_data=1300;
//    err_conflict pulses; mem[0201] stays 1300.
//  5 ifu_rd_req in IDLE/LOAD -> ifu_rd_data unchanged, err_conflict pulse, mem_ready=0.
//  6 reset mid-RUN with a read in flight -> outputs 0, IDLE;
//    after reload-free ld_start/ld_end, read 0200 -> 7200 (contents retained).

Source files
------------

// File: rtl/pdp8_mem_unit.sv
// Unified PDP-8 main memory: one storage array shared by the IFD fetch port
// and the EXEC data read/write ports. A loader fills the array before RUN,
// and mem_ready tells downstream units that fetches may begin.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | after reset; all requests dropped, waiting for ld_start
//  LOAD    | loader writes words on ld_valid; ld_end moves to RUN
//  RUN     | mem_ready=1; IFU/EXEC reads and EXEC writes are served
module pdp8_mem_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_end,
    output logic                  mem_ready,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  err_conflict
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [DATA_WIDTH-1:0] ifu_rd_data_q, ifu_rd_data_d;
    logic [DATA_WIDTH-1:0] exec_rd_data_q, exec_rd_data_d;
    logic                  err_conflict_q, err_conflict_d;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic                  in_run;
    logic                  wr_addr_known;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // Next-state, read-port capture, conflict detection and write-port select.
    always_comb begin
        in_run         = (state_q == ST_RUN);
        state_d        = state_q;
        ifu_rd_data_d  = ifu_rd_data_q;
        exec_rd_data_d = exec_rd_data_q;
        err_conflict_d = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = ld_addr;
        wr_data        = ld_data;

        case (state_q)
            ST_IDLE: if (ld_start) state_d = ST_LOAD;
            ST_LOAD: if (ld_end)   state_d = ST_RUN;
            ST_RUN:  if (ld_start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase

        // Registered so it follows the state register exactly.
        mem_ready_d = (state_d == ST_RUN);

        // Reads see the array before this edge's write, so a same-cycle
        // write to the same address returns the old word.
        if (in_run && ifu_rd_req)  ifu_rd_data_d  = mem[ifu_rd_addr];
        if (in_run && exec_rd_req) exec_rd_data_d = mem[exec_rd_addr];

        if (in_run) err_conflict_d = exec_rd_req & exec_wr_req;
        else        err_conflict_d = ifu_rd_req | exec_rd_req | exec_wr_req;

        // An address with unknown bits must never corrupt the array; in
        // synthesis this reduces to constant true.
        wr_addr_known = ((^exec_wr_addr) !== 1'bx);

        // LOAD and RUN are exclusive, so one write port serves both sources.
        if (state_q == ST_LOAD && ld_valid) begin
            wr_en   = 1'b1;
            wr_addr = ld_addr;
            wr_data = ld_data;
        end else if (in_run && exec_wr_req && !exec_rd_req && wr_addr_known) begin
            wr_en   = 1'b1;
            wr_addr = exec_wr_addr;
            wr_data = exec_wr_data;
        end
    end

    // Control state and registered outputs; reset clears outputs only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            mem_ready_q    <= 1'b0;
            ifu_rd_data_q  <= '0;
            exec_rd_data_q <= '0;
            err_conflict_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_ready_q    <= mem_ready_d;
            ifu_rd_data_q  <= ifu_rd_data_d;
            exec_rd_data_q <= exec_rd_data_d;
            err_conflict_q <= err_conflict_d;
        end
    end

    // Storage array; contents survive reset, but no write lands during it.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) mem[wr_addr] <= wr_data;
    end

    assign mem_ready    = mem_ready_q;
    assign ifu_rd_data  = ifu_rd_data_q;
    assign exec_rd_data = exec_rd_data_q;
    assign err_conflict = err_conflict_q;

endmodule
